// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the memory-mapped machine timer and the data RAM port:
//   - register offsets (decoded from address[4:0])
//   - funct3 load/store mode encodings
//   - CTRL / STATUS bit positions
//   - access-size decode and byte-lane merge helpers
// -----------------------------------------------------------------------------
package timer_pkg;

  // Register offsets within the timer window.
  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_PRESCALE    = 5'h14;
  localparam logic [4:0] OFF_STATUS      = 5'h18;

  // funct3 access modes, shared with the data RAM.
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  // CTRL / STATUS bit indices.
  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;
  localparam int STATUS_PENDING_BIT = 0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } access_size_e;

  // Map funct3 onto an access size; unused encodings become SZ_BAD.
  function automatic access_size_e mode_size(input logic [2:0] mode);
    access_size_e size;
    case (mode)
      MODE_B, MODE_BU: size = SZ_BYTE;
      MODE_H, MODE_HU: size = SZ_HALF;
      MODE_W:          size = SZ_WORD;
      default:         size = SZ_BAD;
    endcase
    return size;
  endfunction

  // Replace only the byte lanes flagged in mask.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/timer_mmio_sync_mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for a 32-bit data-memory responder.
//   i_mode        funct3 access mode
//   i_addr_lo     address[1:0]
//   i_store_data  right-aligned store data from the CPU
//   i_rd_word     full 32-bit word currently held at the addressed location
//   o_wr_data     store data replicated onto every candidate lane
//   o_wr_mask     byte lanes to update (all zero when misaligned)
//   o_rd_data     load data extracted from the lane and sign/zero extended
//   o_misaligned  access is misaligned or uses an unsupported mode
// -----------------------------------------------------------------------------
module mem_lane_align
  import timer_pkg::*;
(
  input  logic [2:0]  i_mode,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rd_word,
  output logic [31:0] o_wr_data,
  output logic [3:0]  o_wr_mask,
  output logic [31:0] o_rd_data,
  output logic        o_misaligned
);

  access_size_e w_size;
  logic         w_signed;
  logic [31:0]  w_shifted;

  assign w_size    = mode_size(i_mode);
  // funct3 bit 2 marks the unsigned load variants.
  assign w_signed  = ~i_mode[2];
  // Bring the addressed lane down to bit 0 for extraction.
  assign w_shifted = i_rd_word >> {i_addr_lo, 3'b000};

  // Lane mask, replicated store data and extended load data per access size.
  always_comb begin
    o_wr_data    = 32'h0000_0000;
    o_wr_mask    = 4'b0000;
    o_rd_data    = 32'h0000_0000;
    o_misaligned = 1'b0;
    case (w_size)
      SZ_BYTE: begin
        o_wr_mask = 4'b0001 << i_addr_lo;
        o_wr_data = {4{i_store_data[7:0]}};
        o_rd_data = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        if (i_addr_lo[0]) begin
          o_misaligned = 1'b1;
        end else begin
          o_wr_mask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wr_data = {2{i_store_data[15:0]}};
          o_rd_data = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
        end
      end
      SZ_WORD: begin
        if (i_addr_lo != 2'b00) begin
          o_misaligned = 1'b1;
        end else begin
          o_wr_mask = 4'b1111;
          o_wr_data = i_store_data;
          o_rd_data = i_rd_word;
        end
      end
      default: begin
        o_misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/timer_mmio_sync.sv
// -----------------------------------------------------------------------------
// timer_mmio_sync
// Memory-mapped machine timer sitting beside the data RAM on the CPU data port.
// 64-bit prescaled free-running counter, 64-bit compare, sticky pending flag
// (write-1-to-clear) and a registered level interrupt.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active low
//   sel         access targets this block (SoC decoder)
//   address     byte address, bits [4:0] decoded
//   write_data  right-aligned store data
//   read_data   load data, extended per mode, valid the cycle after the access
//   we          write enable
//   mode        funct3 access mode
//   timer_irq   registered pending & irq_en
//
// Optional build macro TIMER_SNAPSHOT_EN: a read of MTIME_LO latches the upper
// word into a shadow register which MTIME_HI reads then return, so a LO/HI
// read pair is coherent across a carry.
// -----------------------------------------------------------------------------
module timer_mmio_sync
  import timer_pkg::*;
#(
  parameter int          PRESCALE_W   = 16,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        we,
  input  logic [2:0]  mode,
  output logic        timer_irq
);

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic [1:0]            r_ctrl;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic                  r_pending;
  logic                  r_timer_irq;
  logic [31:0]           r_read_data;
`ifdef TIMER_SNAPSHOT_EN
  logic [31:0]           r_shadow_hi;
`endif

  logic [4:0]  w_off;
  logic [31:0] w_live_word;
  logic [31:0] w_rd_word;
  logic [31:0] w_st_data;
  logic [3:0]  w_st_mask;
  logic [31:0] w_ld_data;
  logic        w_misaligned;
  logic [31:0] w_wr_word;
  logic        w_wr_en;
  logic        w_rd_en;
  logic        w_tick;
  logic        w_cmp_hit;
  logic        w_w1c;
  logic        w_unused_addr;

  localparam logic [PRESCALE_W-1:0] PRESC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  assign w_off         = {address[4:2], 2'b00};
  assign w_unused_addr = ^address[31:5];
  assign w_wr_en       = sel & we & ~w_misaligned;
  assign w_rd_en       = sel & ~we;

  // Live register contents at the addressed word; also the base for partial stores.
  always_comb begin
    w_live_word = 32'h0000_0000;
    case (w_off)
      OFF_MTIME_LO:    w_live_word = r_mtime[31:0];
      OFF_MTIME_HI:    w_live_word = r_mtime[63:32];
      OFF_MTIMECMP_LO: w_live_word = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI: w_live_word = r_mtimecmp[63:32];
      OFF_CTRL:        w_live_word = {30'h0000_0000, r_ctrl};
      OFF_PRESCALE:    w_live_word = 32'(r_prescale);
      OFF_STATUS:      w_live_word = {31'h0000_0000, r_pending};
      default:         w_live_word = 32'h0000_0000;
    endcase
  end

  // Word presented to the load path; MTIME_HI may come from the shadow copy.
  always_comb begin
    w_rd_word = w_live_word;
`ifdef TIMER_SNAPSHOT_EN
    if (w_off == OFF_MTIME_HI) begin
      w_rd_word = r_shadow_hi;
    end else begin
      w_rd_word = w_live_word;
    end
`endif
  end

  mem_lane_align u_lane (
    .i_mode       (mode),
    .i_addr_lo    (address[1:0]),
    .i_store_data (write_data),
    .i_rd_word    (w_rd_word),
    .o_wr_data    (w_st_data),
    .o_wr_mask    (w_st_mask),
    .o_rd_data    (w_ld_data),
    .o_misaligned (w_misaligned)
  );

  assign w_wr_word = byte_merge(w_live_word, w_st_data, w_st_mask);

  assign w_tick    = r_ctrl[CTRL_ENABLE_BIT] & (r_presc_cnt == r_prescale);
  assign w_cmp_hit = r_ctrl[CTRL_ENABLE_BIT] & (r_mtime >= r_mtimecmp);
  // Only a store that actually covers lane 0 with bit 0 set clears pending.
  assign w_w1c     = w_wr_en & (w_off == OFF_STATUS) & w_st_mask[0]
                     & w_st_data[STATUS_PENDING_BIT];

  // Prescaler: counts while enabled and restarts at the reload value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc_cnt <= '0;
    end else if (r_ctrl[CTRL_ENABLE_BIT]) begin
      if (w_tick) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_ONE;
      end
    end
  end

  // mtime: a software write to either word suppresses the increment entirely,
  // so the unwritten word keeps its pre-edge value and no carry crosses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime <= 64'h0000_0000_0000_0000;
    end else if (w_wr_en && (w_off == OFF_MTIME_LO)) begin
      r_mtime[31:0] <= w_wr_word;
    end else if (w_wr_en && (w_off == OFF_MTIME_HI)) begin
      r_mtime[63:32] <= w_wr_word;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // Software-owned configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtimecmp <= MTIMECMP_RST;
      r_ctrl     <= 2'b00;
      r_prescale <= '0;
    end else if (w_wr_en) begin
      case (w_off)
        OFF_MTIMECMP_LO: r_mtimecmp[31:0]  <= w_wr_word;
        OFF_MTIMECMP_HI: r_mtimecmp[63:32] <= w_wr_word;
        OFF_CTRL:        r_ctrl            <= w_wr_word[1:0];
        OFF_PRESCALE:    r_prescale        <= w_wr_word[PRESCALE_W-1:0];
        default:         r_ctrl            <= r_ctrl;
      endcase
    end
  end

  // Pending flag (set beats W1C) and the interrupt that trails it by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending   <= 1'b0;
      r_timer_irq <= 1'b0;
    end else begin
      if (w_cmp_hit) begin
        r_pending <= 1'b1;
      end else if (w_w1c) begin
        r_pending <= 1'b0;
      end
      r_timer_irq <= r_pending & r_ctrl[CTRL_IRQ_EN_BIT];
    end
  end

  // Load data register: updates only on a read access, otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data <= 32'h0000_0000;
    end else if (w_rd_en) begin
      r_read_data <= w_ld_data;
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  // Shadow of mtime[63:32] captured by any well-formed MTIME_LO read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow_hi <= 32'h0000_0000;
    end else if (w_rd_en && !w_misaligned && (w_off == OFF_MTIME_LO)) begin
      r_shadow_hi <= r_mtime[63:32];
    end
  end
`endif

  assign read_data = r_read_data;
  assign timer_irq = r_timer_irq;

endmodule
